// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared widths, types and helpers for the hazard scoreboard.
// Provides reg_addr_t / busy_mask_t plus the per-register "blocking" test
// used by the hazard checker so both files agree on its exact definition.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   busy_mask_t;

  // One-hot decode of a register address.
  function automatic busy_mask_t reg_onehot(input reg_addr_t addr);
    busy_mask_t m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

  // A register blocks Decode when it has a pending long producer, is not x0,
  // and is not being written back this cycle through the write-through path.
  function automatic logic reg_blocking(input busy_mask_t busy,
                                        input reg_addr_t  r,
                                        input logic       wb_valid,
                                        input reg_addr_t  wb_addr,
                                        input logic       bypass);
    return busy[r] && (r != '0) && !(bypass && wb_valid && (wb_addr == r));
  endfunction

endpackage

// File: rtl/sb_hazard_check.sv
// sb_hazard_check: combinational RAW / WAW / capacity evaluation for Decode.
// Latency: purely combinational. Backpressure: none; results feed o_stall_D.
// Ports: busy mask + pending count in, Decode operands and writeback in,
//        raw / waw / full hazard flags out.
module sb_hazard_check
  import hazard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_BYPASS       = 1,
  parameter int CNT_W           = 3
) (
  input  logic [NUM_REGS-1:0]   busy,
  input  logic [CNT_W-1:0]      cnt,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_wren,
  input  logic                  is_long,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  raw,
  output logic                  waw,
  output logic                  full
);

  localparam logic BYPASS = (WB_BYPASS != 0);

  logic rs1_blk;
  logic rs2_blk;
  logic rd_blk;
  logic wb_frees_slot;

  always_comb begin
    rs1_blk = reg_blocking(busy, rs1_addr, wb_valid, wb_addr, BYPASS);
    rs2_blk = reg_blocking(busy, rs2_addr, wb_valid, wb_addr, BYPASS);
    rd_blk  = reg_blocking(busy, rd_addr,  wb_valid, wb_addr, BYPASS);

    // A legal writeback frees a slot at this edge regardless of bypass mode,
    // so a full table does not need to stall the incoming long op.
    wb_frees_slot = wb_valid && busy[wb_addr];

    raw  = (rs1_used && rs1_blk) || (rs2_used && rs2_blk);
    waw  = rd_wren && rd_blk;
    full = is_long && rd_wren && (rd_addr != '0) &&
           (cnt == CNT_W'(MAX_OUTSTANDING)) && !wb_frees_slot;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks registers with an outstanding long-latency write
// and stalls Decode on RAW/WAW hazards or when the pending table is full.
// Latency: stall is combinational; reservation visible 1 cycle after issue,
// release same cycle (WB_BYPASS=1) or next cycle (WB_BYPASS=0).
// Backpressure: o_stall_D holds Fetch/Decode; i_hold_D blocks issue only.
// Optional macro SB_STATS_EN adds o_stall_cycles / o_hazard_raw_cycles.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_*_D                     Decode instruction fields
//   i_flush_E                 squash the instruction issued last cycle
//   i_wb_valid, i_wb_addr     long-op completion
//   o_stall_D                 combinational Decode stall
//   o_busy_mask, o_pending_cnt, o_wb_err   registered status
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_BYPASS       = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_valid_D,
  input  logic                                 i_hold_D,
  input  logic [4:0]                           i_rs1_addr_D,
  input  logic [4:0]                           i_rs2_addr_D,
  input  logic                                 i_rs1_used_D,
  input  logic                                 i_rs2_used_D,
  input  logic [4:0]                           i_rd_addr_D,
  input  logic                                 i_rd_wren_D,
  input  logic                                 i_long_D,
  input  logic                                 i_flush_E,
  input  logic                                 i_wb_valid,
  input  logic [4:0]                           i_wb_addr,
  output logic                                 o_stall_D,
  output logic [31:0]                          o_busy_mask,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_pending_cnt,
  output logic                                 o_wb_err
`ifdef SB_STATS_EN
  ,
  output logic [31:0]                          o_stall_cycles,
  output logic [31:0]                          o_hazard_raw_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // State
  busy_mask_t       busy_q;
  logic [CNT_W-1:0] cnt_q;
  reg_addr_t        last_rd_q;
  logic             last_vld_q;
  logic             wb_err_q;

  // Hazard evaluation
  logic raw;
  logic waw;
  logic full;

  sb_hazard_check #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .WB_BYPASS      (WB_BYPASS),
    .CNT_W          (CNT_W)
  ) u_check (
    .busy    (busy_q),
    .cnt     (cnt_q),
    .rs1_addr(i_rs1_addr_D),
    .rs2_addr(i_rs2_addr_D),
    .rs1_used(i_rs1_used_D),
    .rs2_used(i_rs2_used_D),
    .rd_addr (i_rd_addr_D),
    .rd_wren (i_rd_wren_D),
    .is_long (i_long_D),
    .wb_valid(i_wb_valid),
    .wb_addr (i_wb_addr),
    .raw     (raw),
    .waw     (waw),
    .full    (full)
  );

  // Next-state logic
  logic             issue;
  logic             issue_long;
  logic             wb_hit;
  logic             flush_undo;
  busy_mask_t       set_mask;
  busy_mask_t       clr_mask;
  logic [1:0]       n_clr;
  busy_mask_t       busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    o_stall_D  = i_valid_D && (raw || waw || full);
    issue      = i_valid_D && !o_stall_D && !i_hold_D;
    issue_long = issue && i_long_D && i_rd_wren_D && (i_rd_addr_D != '0);

    // busy_q[0] is never set, so this also rejects writebacks to x0.
    wb_hit     = i_wb_valid && busy_q[i_wb_addr];
    flush_undo = i_flush_E && last_vld_q;

    set_mask = issue_long ? reg_onehot(i_rd_addr_D) : '0;
    clr_mask = '0;
    if (wb_hit)     clr_mask = clr_mask | reg_onehot(i_wb_addr);
    if (flush_undo) clr_mask = clr_mask | reg_onehot(last_rd_q);

    // Flush-undo and writeback of the same register retire one producer.
    if (wb_hit && flush_undo && (i_wb_addr == last_rd_q)) n_clr = 2'd1;
    else n_clr = {1'b0, wb_hit} + {1'b0, flush_undo};

    // Set is applied after clear: a new producer on the retiring register
    // keeps the bit, while the count still nets +1 - 1.
    busy_nxt    = (busy_q & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
    cnt_nxt     = cnt_q + CNT_W'(issue_long) - CNT_W'(n_clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      last_rd_q  <= '0;
      last_vld_q <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_nxt;
      cnt_q      <= cnt_nxt;
      last_vld_q <= issue_long;
      if (issue_long) last_rd_q <= i_rd_addr_D;
      wb_err_q   <= i_wb_valid && !wb_hit;
    end
  end

  assign o_busy_mask   = busy_q;
  assign o_pending_cnt = cnt_q;
  assign o_wb_err      = wb_err_q;

`ifdef SB_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] raw_cycles_q;

  // Saturating counters; raw is only meaningful while Decode holds a
  // valid instruction, so it is qualified the same way as the stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cycles_q <= '0;
      raw_cycles_q   <= '0;
    end else begin
      if (o_stall_D && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (i_valid_D && raw && (raw_cycles_q != '1))
        raw_cycles_q <= raw_cycles_q + 32'd1;
    end
  end

  assign o_stall_cycles      = stall_cycles_q;
  assign o_hazard_raw_cycles = raw_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven bench for hazard_scoreboard
// (MAX_OUTSTANDING=4, WB_BYPASS=1). Each row drives one Decode cycle, checks
// the combinational stall, queues the expected registered state and
// compares it after the clock edge.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        valid_d, hold_d;
  logic [4:0]  rs1, rs2, rd, wba;
  logic        u1, u2, wren, lng, flush, wbv;
  logic        stall;
  logic [31:0] busy_mask;
  logic [2:0]  pend_cnt;
  logic        wb_err;

  hazard_scoreboard #(.MAX_OUTSTANDING(4), .WB_BYPASS(1)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_valid_D    (valid_d),
    .i_hold_D     (hold_d),
    .i_rs1_addr_D (rs1),
    .i_rs2_addr_D (rs2),
    .i_rs1_used_D (u1),
    .i_rs2_used_D (u2),
    .i_rd_addr_D  (rd),
    .i_rd_wren_D  (wren),
    .i_long_D     (lng),
    .i_flush_E    (flush),
    .i_wb_valid   (wbv),
    .i_wb_addr    (wba),
    .o_stall_D    (stall),
    .o_busy_mask  (busy_mask),
    .o_pending_cnt(pend_cnt),
    .o_wb_err     (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld, hold;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        wren, lng, flush, wbv;
    logic [4:0]  wba;
    logic        stall;
    logic [31:0] mask;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] mask;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, v, h,
                              input logic [4:0] a1, a2,
                              input logic f1, f2,
                              input logic [4:0] d,
                              input logic w, l, fl, wv,
                              input logic [4:0] wa,
                              input logic es,
                              input logic [31:0] em,
                              input int ec,
                              input logic ee);
    vec_t t;
    t.rst = r; t.vld = v; t.hold = h; t.rs1 = a1; t.rs2 = a2;
    t.u1 = f1; t.u2 = f2; t.rd = d; t.wren = w; t.lng = l;
    t.flush = fl; t.wbv = wv; t.wba = wa;
    t.stall = es; t.mask = em; t.cnt = 3'(ec); t.err = ee;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string nm);
    exp_t e;
    @(negedge clk);
    rst = t.rst; valid_d = t.vld; hold_d = t.hold;
    rs1 = t.rs1; rs2 = t.rs2; u1 = t.u1; u2 = t.u2;
    rd = t.rd; wren = t.wren; lng = t.lng;
    flush = t.flush; wbv = t.wbv; wba = t.wba;
    #1;
    chk({nm, ".stall"}, {31'd0, stall}, {31'd0, t.stall});
    e.mask = t.mask; e.cnt = t.cnt; e.err = t.err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.queue: got empty, expected one entry", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".mask"}, busy_mask, e.mask);
      chk({nm, ".cnt"},  {29'd0, pend_cnt}, {29'd0, e.cnt});
      chk({nm, ".err"},  {31'd0, wb_err},   {31'd0, e.err});
    end
  endtask

  initial begin
    rst = 1'b1; valid_d = 0; hold_d = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
    rd = 0; wren = 0; lng = 0; flush = 0; wbv = 0; wba = 0;

    //          rst v h rs1 rs2 u1 u2 rd wr lg fl wv wa   stall mask        cnt err
    tbl.push_back(mk(1,0,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,  0, 32'h0,      0,0)); // reset
    tbl.push_back(mk(0,0,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,  0, 32'h0,      0,0)); // idle after reset
    tbl.push_back(mk(0,1,0, 1, 0, 1,0, 5, 1,1, 0,0, 0,  0, 32'h20,     1,0)); // load x5
    tbl.push_back(mk(0,1,0, 5, 0, 1,0, 8, 1,0, 0,0, 0,  1, 32'h20,     1,0)); // add reads x5: raw
    tbl.push_back(mk(0,1,0, 5, 0, 1,0, 8, 1,0, 0,1, 5,  0, 32'h0,      0,0)); // wb x5 bypasses
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 0, 1,1, 0,0, 0,  0, 32'h0,      0,0)); // long to x0
    tbl.push_back(mk(0,1,0, 0, 0, 1,1, 3, 1,0, 0,0, 0,  0, 32'h0,      0,0)); // read x0
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 1, 1,1, 0,0, 0,  0, 32'h2,      1,0)); // long x1
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 2, 1,1, 0,0, 0,  0, 32'h6,      2,0)); // long x2
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 3, 1,1, 0,0, 0,  0, 32'hE,      3,0)); // long x3
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 4, 1,1, 0,0, 0,  0, 32'h1E,     4,0)); // long x4: full
    tbl.push_back(mk(0,1,0, 0, 0, 0,0,10, 1,1, 0,0, 0,  1, 32'h1E,     4,0)); // fifth stalls
    tbl.push_back(mk(0,1,0, 0, 0, 0,0,10, 1,1, 0,1, 2,  0, 32'h41A,    4,0)); // wb x2 frees slot
    tbl.push_back(mk(0,0,0, 0, 0, 0,0, 0, 0,0, 0,1, 1,  0, 32'h418,    3,0)); // drain
    tbl.push_back(mk(0,0,0, 0, 0, 0,0, 0, 0,0, 0,1, 3,  0, 32'h410,    2,0));
    tbl.push_back(mk(0,0,0, 0, 0, 0,0, 0, 0,0, 0,1, 4,  0, 32'h400,    1,0));
    tbl.push_back(mk(0,0,0, 0, 0, 0,0, 0, 0,0, 0,1,10,  0, 32'h0,      0,0));
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 7, 1,1, 0,0, 0,  0, 32'h80,     1,0)); // long x7
    tbl.push_back(mk(0,0,0, 0, 0, 0,0, 0, 0,0, 1,0, 0,  0, 32'h0,      0,0)); // flush undoes x7
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 7, 1,1, 0,0, 0,  0, 32'h80,     1,0)); // long x7 again
    tbl.push_back(mk(0,0,0, 0, 0, 0,0, 0, 0,0, 1,1, 7,  0, 32'h0,      0,0)); // flush + wb x7
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 6, 1,1, 0,0, 0,  0, 32'h40,     1,0)); // long x6
    tbl.push_back(mk(0,0,0, 6, 0, 1,0, 9, 1,0, 0,0, 0,  0, 32'h40,     1,0)); // invalid: no stall
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 6, 1,1, 0,0, 0,  1, 32'h40,     1,0)); // waw on x6
    tbl.push_back(mk(0,1,0, 0, 0, 0,0, 6, 1,1, 0,1, 6,  0, 32'h40,     1,0)); // wb x6: set wins
    tbl.push_back(mk(0,1,0, 0, 6, 0,1, 0, 0,0, 0,0, 0,  1, 32'h40,     1,0)); // raw via rs2
    tbl.push_back(mk(0,1,0, 0, 6, 0,0, 0, 0,0, 0,0, 0,  0, 32'h40,     1,0)); // rs2 unused
    tbl.push_back(mk(0,1,1, 0, 0, 0,0,11, 1,1, 0,0, 0,  0, 32'h40,     1,0)); // held: no issue
    tbl.push_back(mk(0,0,0, 0, 0, 0,0, 0, 0,0, 1,0, 0,  0, 32'h40,     1,0)); // flush, nothing to undo

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("row%0d", i));

    // Writeback error pulse: non-pending x9, then x0; each lasts one cycle.
    apply(mk(0,0,0, 0,0, 0,0, 0, 0,0, 0,1, 9, 0, 32'h40, 1,1), "wberr9");
    apply(mk(0,0,0, 0,0, 0,0, 0, 0,0, 0,0, 0, 0, 32'h40, 1,0), "wberr9_clr");
    apply(mk(0,0,0, 0,0, 0,0, 0, 0,0, 0,1, 0, 0, 32'h40, 1,1), "wberr0");
    apply(mk(0,0,0, 0,0, 0,0, 0, 0,0, 0,0, 0, 0, 32'h40, 1,0), "wberr0_clr");

    // Reset with three pending discards everything, including an issue in
    // the reset cycle; a following flush must not underflow the count.
    apply(mk(0,1,0, 0,0, 0,0,12, 1,1, 0,0, 0, 0, 32'h1040, 2,0), "rst_pend12");
    apply(mk(0,1,0, 0,0, 0,0,13, 1,1, 0,0, 0, 0, 32'h3040, 3,0), "rst_pend13");
    apply(mk(1,1,0, 0,0, 0,0,14, 1,1, 0,0, 0, 0, 32'h0,    0,0), "rst_mid");
    apply(mk(0,0,0, 0,0, 0,0, 0, 0,0, 1,0, 0, 0, 32'h0,    0,0), "rst_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
